data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-port arbiter sharing the single-port data memory between the CPU load/store stage (port 0) and the UART program/data loader (port 1). It accepts one request per port through a req/ack handshake and arbitrates round-robin when both ports request at once. It drives the memory's write strobe, address and write data from registers, and returns the synchronous read data with the ack. It also produces the CPU stall signal and flags misaligned or out-of-range accesses without touching memory.

## Interface
- `MEM_WORDS`, 16384: number of 32-bit words in data memory; byte addresses at or above 4*MEM_WORDS are out of range.
- `Clock  in  1`: sole clock; all state changes on the rising edge.
- `Reset  in  1`: asynchronous, active-high reset.
- `cpu_req  in  1`: port 0 request; held with its fields until `cpu_ack`.
- `cpu_we  in  1`: port 0 write (1) or read (0).
- `cpu_addr  in  32`: port 0 byte address.
- `cpu_wdata  in  32`: port 0 write data.
- `cpu_ack  out  1`: port 0 one-cycle completion pulse.
- `cpu_err  out  1`: valid with `cpu_ack`; access was rejected.
- `cpu_rdata  out  32`: port 0 read data, valid with `cpu_ack` on a read.
- `cpu_stall  out  1`: `cpu_req & ~cpu_ack`.
- `ld_req`, `ld_we`, `ld_addr[31:0]`, `ld_wdata[31:0]`, `ld_ack`, `ld_err`, `ld_rdata[31:0]`: port 1 equivalents; no stall output.
- `MemWrite  out  1`: memory write strobe.
- `Address  out  32`: memory byte address.
- `WriteData  out  32`: memory write data.
- `ReadData  in  32`: memory read data, registered inside the memory and valid the cycle after `Address` is presented.

## Operation
- The state machine has three states: IDLE, ISSUE and RESP. A `gnt` register records the owning port, and a `last` register records the last port served.
- **IDLE.** If any `req` is high, pick the winner.
  - A single requester wins.
  - If both request, the port not equal to `last` wins. `last` resets to 1, so the CPU wins the first tie.
  - The winner's access is checked. `addr[1:0] != 0`, or `addr >= 4*MEM_WORDS`, makes it bad.
  - A good access loads `Address`, `WriteData` and `MemWrite = we`, then moves to ISSUE.
  - A bad access leaves `MemWrite = 0`, latches `err_pending`, then moves to ISSUE.
- **ISSUE.** The memory performs the access at the end of this cycle. Clear `MemWrite` and go to RESP.
- **RESP.**
  - Pulse the owner's `ack` for one cycle.
  - `err` equals `err_pending`.
  - `rdata` equals `ReadData` for a good read and 0 otherwise.
  - Update `last` to the owner.
  - Arbitration in this cycle considers only the other port's `req`, because the acked port changes its fields at this edge.
    - If the other port requests, run the IDLE load logic for it and go to ISSUE.
    - Otherwise go to IDLE.
- Writes to memory happen only for good accesses and only on the ISSUE-ending edge.

## Timing
- **Reset values:** all `ack`, `err` and `MemWrite` are 0; `Address`, `WriteData` and all `rdata` are 0; state is IDLE; `last` is 1.
- **Latency:** `req` is sampled high in IDLE at cycle N, `MemWrite`/`Address` are valid in cycle N+1, and `ack` (with `rdata` or `err`) arrives in cycle N+2.
- **Throughput:**
  - Alternating ports under contention sustain one access every 2 cycles.
  - The same port back-to-back takes 3 cycles (RESP, then IDLE, then ISSUE).
- **Handshake rules:**
  - `req` and its fields must be stable from assertion until the `ack` cycle.
  - A requester may drop `req` only after `ack`.
  - A `req` that drops early while the port owns the bus is a protocol violation. Its behaviour is unspecified, but it must not deadlock the arbiter.
- **Simultaneous events:** both ports requesting in IDLE is resolved by `last`; there is no starvation.
- **Reset mid-operation:**
  - Asynchronous `Reset` forces `MemWrite` to 0 immediately. An access in ISSUE is dropped and never written.
  - No `ack` is given for a pending access. Requesters re-issue after reset.
- `cpu_stall` is combinational and high from `cpu_req` until and excluding the `cpu_ack` cycle.

## Structure
- Place the state encodings (IDLE, ISSUE, RESP), the port indices (`PORT_CPU = 0`, `PORT_LD = 1`) and the default `MEM_WORDS` in the shared `definitions.v`.
- Add one natural sub-module, `mem_access_check`. It is combinational: it takes the address and `MEM_WORDS` and outputs `misaligned` and `out_of_range`, and is instantiated once on the muxed winner's address.
- The rest of the design (the state machine, the winner mux and the output registers) stays flat in `data_mem_arbiter`.

## Test plan
- **CPU write then read:** `cpu_req`/`cpu_we=1`, `addr=0x10`, `wdata=0xDEADBEEF` → `MemWrite=1`, `Address=0x10` at N+1, `cpu_ack` at N+2. A following read of 0x10 → `cpu_rdata=0xDEADBEEF`, `cpu_err=0`.
- **Contention from reset:** both ports `req` at once, CPU reads 0x0, loader writes 0x4 → CPU acked at N+2, loader issued at N+3 and acked at N+4. With both held continuously, the grants alternate.
- **Misaligned:** `ld_req` with `ld_addr=0x6` → `ld_ack=1`, `ld_err=1` at N+2, `MemWrite` never asserted.
- **Out of range:** `MEM_WORDS=16`, `cpu_addr=0x40` → `cpu_err=1`, no write. `0x3C` → normal access.
- **Stall:** `cpu_req` while the loader owns the bus → `cpu_stall=1` for every cycle until `cpu_ack`, then 0.
- **Reset during ISSUE of a write to 0x20 (data 0x1234):** `MemWrite` drops asynchronously and no `ack` is given. A read of 0x20 after reset returns the pre-write contents.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// Shared constants and types for the data-memory arbiter: FSM encodings,
// port indices, bus widths and the default memory size.
package data_mem_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEFAULT_MEM_WORDS = 16384;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LD  = 1'b1;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } memReq_t;

endpackage

// File: rtl/data_mem_arbiter_mem_access_check.sv
// Combinational legality check of a byte address against word alignment
// and the data-memory size.
module mem_access_check
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_WORDS = DEFAULT_MEM_WORDS
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              misaligned,
  output logic              out_of_range
);

  // Limit is kept two bits wider so 4*MEM_WORDS cannot wrap.
  localparam logic [ADDR_W+1:0] LIMIT = {ADDR_W'(MEM_WORDS), 2'b00};

  assign misaligned   = |addr[1:0];
  assign out_of_range = ({2'b00, addr} >= LIMIT);

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU
// load/store stage and the UART loader, with registered memory-side outputs.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_WORDS = DEFAULT_MEM_WORDS
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic              ld_err,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WriteData,
  input  logic [DATA_W-1:0] ReadData
);

  logic [1:0] state, stateNext;
  logic       gnt, gntNext;
  logic       last, lastNext;
  logic       errPending, errPendingNext;
  logic       isRead, isReadNext;
  logic       cpuRdSel, cpuRdSelNext;
  logic       ldRdSel, ldRdSelNext;
  logic       memWriteNext;
  logic [ADDR_W-1:0] addressNext;
  logic [DATA_W-1:0] writeDataNext;
  logic       cpuAckNext, ldAckNext, cpuErrNext, ldErrNext;

  memReq_t cpuReq, ldReq, sel;
  logic    selPort, selValid;
  logic    misaligned, outOfRange;

  assign cpuReq = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
  assign ldReq  = '{we: ld_we,  addr: ld_addr,  wdata: ld_wdata};

  // Candidate port: full arbitration in IDLE, only the non-owner in RESP.
  always_comb begin
    selPort  = PORT_CPU;
    selValid = 1'b0;
    if (state == IDLE) begin
      selValid = cpu_req | ld_req;
      if (cpu_req && ld_req) selPort = ~last;
      else                   selPort = cpu_req ? PORT_CPU : PORT_LD;
    end else if (state == RESP) begin
      selPort  = ~gnt;
      selValid = (gnt == PORT_CPU) ? ld_req : cpu_req;
    end
  end

  assign sel = (selPort == PORT_LD) ? ldReq : cpuReq;

  mem_access_check #(.MEM_WORDS(MEM_WORDS)) uCheck (
    .addr         (sel.addr),
    .misaligned   (misaligned),
    .out_of_range (outOfRange)
  );

  always_comb begin
    stateNext      = state;
    gntNext        = gnt;
    lastNext       = last;
    errPendingNext = errPending;
    isReadNext     = isRead;
    memWriteNext   = 1'b0;
    addressNext    = Address;
    writeDataNext  = WriteData;
    cpuAckNext     = 1'b0;
    ldAckNext      = 1'b0;
    cpuErrNext     = 1'b0;
    ldErrNext      = 1'b0;
    cpuRdSelNext   = 1'b0;
    ldRdSelNext    = 1'b0;
    case (state)
      IDLE, RESP: begin
        if (state == RESP) lastNext = gnt;
        stateNext = IDLE;
        if (selValid) begin
          stateNext      = ISSUE;
          gntNext        = selPort;
          errPendingNext = misaligned | outOfRange;
          isReadNext     = ~sel.we;
          if (!(misaligned | outOfRange)) begin
            addressNext   = sel.addr;
            writeDataNext = sel.wdata;
            memWriteNext  = sel.we;
          end
        end
      end
      ISSUE: begin
        // Ack/err registers rise with the RESP cycle; rdata follows ReadData.
        stateNext = RESP;
        if (gnt == PORT_CPU) begin
          cpuAckNext   = 1'b1;
          cpuErrNext   = errPending;
          cpuRdSelNext = isRead & ~errPending;
        end else begin
          ldAckNext   = 1'b1;
          ldErrNext   = errPending;
          ldRdSelNext = isRead & ~errPending;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      gnt        <= PORT_CPU;
      last       <= PORT_LD;
      errPending <= 1'b0;
      isRead     <= 1'b0;
      cpuRdSel   <= 1'b0;
      ldRdSel    <= 1'b0;
      MemWrite   <= 1'b0;
      Address    <= '0;
      WriteData  <= '0;
      cpu_ack    <= 1'b0;
      ld_ack     <= 1'b0;
      cpu_err    <= 1'b0;
      ld_err     <= 1'b0;
    end else begin
      state      <= stateNext;
      gnt        <= gntNext;
      last       <= lastNext;
      errPending <= errPendingNext;
      isRead     <= isReadNext;
      cpuRdSel   <= cpuRdSelNext;
      ldRdSel    <= ldRdSelNext;
      MemWrite   <= memWriteNext;
      Address    <= addressNext;
      WriteData  <= writeDataNext;
      cpu_ack    <= cpuAckNext;
      ld_ack     <= ldAckNext;
      cpu_err    <= cpuErrNext;
      ld_err     <= ldErrNext;
    end
  end

  assign cpu_rdata = cpuRdSel ? ReadData : '0;
  assign ld_rdata  = ldRdSel  ? ReadData : '0;
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter with a 16-word
// registered-read memory model attached to the memory port.
module tb_data_mem_arbiter;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        cpu_req, cpu_we, ld_req, ld_we;
  logic [31:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata;
  logic        cpu_ack, cpu_err, cpu_stall, ld_ack, ld_err;
  logic [31:0] cpu_rdata, ld_rdata;
  logic        MemWrite;
  logic [31:0] Address, WriteData, ReadData;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [16];
  logic        memReady = 1'b0;

  data_mem_arbiter #(.MEM_WORDS(16)) dut (
    .Clock(Clock), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ack(ld_ack), .ld_err(ld_err), .ld_rdata(ld_rdata),
    .MemWrite(MemWrite), .Address(Address), .WriteData(WriteData), .ReadData(ReadData)
  );

  always #5 Clock = ~Clock;

  // Memory model: word i starts as 0xA0000000+i; read data is registered.
  always @(posedge Clock) begin
    if (!memReady) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 + 32'(i);
      memReady <= 1'b1;
    end else if (MemWrite) begin
      mem[Address[5:2]] <= WriteData;
    end
    ReadData <= mem[Address[5:2]];
  end

  task automatic test_reset();
    Reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
    repeat (2) @(negedge Clock);
    checks++; if ({cpu_ack, ld_ack, cpu_err, ld_err, MemWrite, cpu_stall} !== 6'b0) begin failures++; $display("FAIL reset_flags got=%b exp=000000", {cpu_ack, ld_ack, cpu_err, ld_err, MemWrite, cpu_stall}); end
    checks++; if (Address !== 32'h0 || WriteData !== 32'h0) begin failures++; $display("FAIL reset_bus got=%h/%h exp=0/0", Address, WriteData); end
    checks++; if (cpu_rdata !== 32'h0 || ld_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0/0", cpu_rdata, ld_rdata); end
    Reset = 1'b0;
    @(negedge Clock);
  endtask

  task automatic test_contention();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0;
    ld_req = 1; ld_we = 1; ld_addr = 32'h4; ld_wdata = 32'hCAFE_F00D;
    @(negedge Clock);
    checks++; if (MemWrite !== 1'b0 || Address !== 32'h0) begin failures++; $display("FAIL cont_issue_cpu got=%b/%h exp=0/0", MemWrite, Address); end
    @(negedge Clock);
    checks++; if (cpu_ack !== 1'b1 || ld_ack !== 1'b0 || cpu_err !== 1'b0) begin failures++; $display("FAIL cont_ack_cpu got=%b%b%b exp=100", cpu_ack, ld_ack, cpu_err); end
    checks++; if (cpu_rdata !== 32'hA000_0000) begin failures++; $display("FAIL cont_rdata_cpu got=%h exp=a0000000", cpu_rdata); end
    cpu_req = 0;
    @(negedge Clock);
    checks++; if (MemWrite !== 1'b1 || Address !== 32'h4 || WriteData !== 32'hCAFE_F00D) begin failures++; $display("FAIL cont_issue_ld got=%b/%h/%h exp=1/4/cafef00d", MemWrite, Address, WriteData); end
    @(negedge Clock);
    checks++; if (ld_ack !== 1'b1 || ld_err !== 1'b0 || cpu_ack !== 1'b0) begin failures++; $display("FAIL cont_ack_ld got=%b%b%b exp=100", ld_ack, ld_err, cpu_ack); end
    ld_req = 0;
    @(negedge Clock);
    checks++; if (mem[1] !== 32'hCAFE_F00D) begin failures++; $display("FAIL cont_mem got=%h exp=cafef00d", mem[1]); end
  endtask

  task automatic test_alternate();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h8;
    ld_req = 1; ld_we = 0; ld_addr = 32'hC;
    for (int i = 1; i <= 8; i++) begin
      @(negedge Clock);
      checks++;
      if (cpu_ack !== ((i % 4) == 2) || ld_ack !== ((i % 4) == 0)) begin
        failures++; $display("FAIL alt_acks cyc=%0d got=%b%b exp=%b%b", i, cpu_ack, ld_ack, (i % 4) == 2, (i % 4) == 0);
      end
      if (cpu_ack && cpu_rdata !== 32'hA000_0002) begin failures++; $display("FAIL alt_rdata_cpu got=%h exp=a0000002", cpu_rdata); end
      if (ld_ack && ld_rdata !== 32'hA000_0003) begin failures++; $display("FAIL alt_rdata_ld got=%h exp=a0000003", ld_rdata); end
    end
    cpu_req = 0; ld_req = 0;
    @(negedge Clock);
  endtask

  task automatic test_write_read();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL wr_stall got=%b exp=1", cpu_stall); end
    @(negedge Clock);
    checks++; if (MemWrite !== 1'b1 || Address !== 32'h10 || WriteData !== 32'hDEAD_BEEF || cpu_ack !== 1'b0) begin failures++; $display("FAIL wr_issue got=%b/%h/%h/%b exp=1/10/deadbeef/0", MemWrite, Address, WriteData, cpu_ack); end
    @(negedge Clock);
    checks++; if (cpu_ack !== 1'b1 || cpu_err !== 1'b0 || cpu_stall !== 1'b0 || MemWrite !== 1'b0) begin failures++; $display("FAIL wr_ack got=%b%b%b%b exp=1000", cpu_ack, cpu_err, cpu_stall, MemWrite); end
    cpu_req = 0;
    @(negedge Clock);
    checks++; if (cpu_ack !== 1'b0) begin failures++; $display("FAIL wr_ack_pulse got=%b exp=0", cpu_ack); end
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    @(negedge Clock);
    checks++; if (MemWrite !== 1'b0 || Address !== 32'h10) begin failures++; $display("FAIL rd_issue got=%b/%h exp=0/10", MemWrite, Address); end
    @(negedge Clock);
    checks++; if (cpu_ack !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_data got=%b%b/%h exp=10/deadbeef", cpu_ack, cpu_err, cpu_rdata); end
    cpu_req = 0;
    @(negedge Clock);
  endtask

  task automatic test_misaligned();
    ld_req = 1; ld_we = 1; ld_addr = 32'h6; ld_wdata = 32'hFFFF_FFFF;
    @(negedge Clock);
    checks++; if (MemWrite !== 1'b0) begin failures++; $display("FAIL mis_issue got=%b exp=0", MemWrite); end
    @(negedge Clock);
    checks++; if (ld_ack !== 1'b1 || ld_err !== 1'b1 || MemWrite !== 1'b0 || ld_rdata !== 32'h0) begin failures++; $display("FAIL mis_ack got=%b%b%b/%h exp=110/0", ld_ack, ld_err, MemWrite, ld_rdata); end
    ld_req = 0;
    @(negedge Clock);
    checks++; if (mem[1] !== 32'hCAFE_F00D) begin failures++; $display("FAIL mis_mem got=%h exp=cafef00d", mem[1]); end
  endtask

  task automatic test_out_of_range();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'h0000_0BAD;
    @(negedge Clock);
    checks++; if (MemWrite !== 1'b0) begin failures++; $display("FAIL oor_issue got=%b exp=0", MemWrite); end
    @(negedge Clock);
    checks++; if (cpu_ack !== 1'b1 || cpu_err !== 1'b1) begin failures++; $display("FAIL oor_ack got=%b%b exp=11", cpu_ack, cpu_err); end
    cpu_req = 0;
    @(negedge Clock);
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h3C; cpu_wdata = 32'h5555_AAAA;
    @(negedge Clock);
    checks++; if (MemWrite !== 1'b1 || Address !== 32'h3C) begin failures++; $display("FAIL edge_issue got=%b/%h exp=1/3c", MemWrite, Address); end
    @(negedge Clock);
    checks++; if (cpu_ack !== 1'b1 || cpu_err !== 1'b0) begin failures++; $display("FAIL edge_ack got=%b%b exp=10", cpu_ack, cpu_err); end
    cpu_req = 0;
    @(negedge Clock);
    checks++; if (mem[15] !== 32'h5555_AAAA || mem[0] !== 32'hA000_0000) begin failures++; $display("FAIL oor_mem got=%h/%h exp=5555aaaa/a0000000", mem[15], mem[0]); end
  endtask

  task automatic test_stall();
    ld_req = 1; ld_we = 1; ld_addr = 32'h8; ld_wdata = 32'h0000_0077;
    @(negedge Clock);
    checks++; if (MemWrite !== 1'b1 || Address !== 32'h8) begin failures++; $display("FAIL stall_ld_issue got=%b/%h exp=1/8", MemWrite, Address); end
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h14;
    #1;
    checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL stall_c1 got=%b exp=1", cpu_stall); end
    @(negedge Clock);
    checks++; if (ld_ack !== 1'b1 || cpu_stall !== 1'b1) begin failures++; $display("FAIL stall_c2 got=%b%b exp=11", ld_ack, cpu_stall); end
    ld_req = 0;
    @(negedge Clock);
    checks++; if (cpu_stall !== 1'b1 || cpu_ack !== 1'b0 || Address !== 32'h14) begin failures++; $display("FAIL stall_c3 got=%b%b/%h exp=10/14", cpu_stall, cpu_ack, Address); end
    @(negedge Clock);
    checks++; if (cpu_ack !== 1'b1 || cpu_stall !== 1'b0 || cpu_rdata !== 32'hA000_0005) begin failures++; $display("FAIL stall_c4 got=%b%b/%h exp=10/a0000005", cpu_ack, cpu_stall, cpu_rdata); end
    cpu_req = 0;
    #1;
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL stall_done got=%b exp=0", cpu_stall); end
    @(negedge Clock);
  endtask

  task automatic test_reset_mid_issue();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'h0000_1234;
    @(negedge Clock);
    checks++; if (MemWrite !== 1'b1 || Address !== 32'h20) begin failures++; $display("FAIL rst_issue got=%b/%h exp=1/20", MemWrite, Address); end
    Reset = 1'b1;
    #1;
    checks++; if (MemWrite !== 1'b0) begin failures++; $display("FAIL rst_async got=%b exp=0", MemWrite); end
    cpu_req = 0;
    repeat (2) begin
      @(negedge Clock);
      checks++; if (cpu_ack !== 1'b0) begin failures++; $display("FAIL rst_noack got=%b exp=0", cpu_ack); end
    end
    Reset = 1'b0;
    @(negedge Clock);
    checks++; if (cpu_ack !== 1'b0 || mem[8] !== 32'hA000_0008) begin failures++; $display("FAIL rst_mem got=%b/%h exp=0/a0000008", cpu_ack, mem[8]); end
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
    repeat (2) @(negedge Clock);
    checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== 32'hA000_0008) begin failures++; $display("FAIL rst_readback got=%b/%h exp=1/a0000008", cpu_ack, cpu_rdata); end
    cpu_req = 0;
    @(negedge Clock);
  endtask

  initial begin
    test_reset();
    test_contention();
    test_alternate();
    test_write_read();
    test_misaligned();
    test_out_of_range();
    test_stall();
    test_reset_mid_issue();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
